// File: rtl/option_store_if.sv
// Parser/solver side bundle of the option store: load strobes in, read pipeline and
// board status out.
interface option_store_if #(
    parameter int unsigned MAX_LINES = 22,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned W         = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                           wr_valid;
    logic                           wr_header;
    logic [W-1:0]                   wr_data;
    logic                           board_done;
    logic                           rd_req;
    logic [4:0]                     rd_line;
    logic [CW-2:0]                  rd_idx;
    logic                           rd_valid;
    logic [W-1:0]                   rd_data;
    logic                           rd_oob;
    logic [MAX_LINES-1:0][CW-1:0]   line_count;
    logic                           ready;
    logic                           overflow;
    logic                           proto_err;

    modport master (
        output wr_valid, wr_header, wr_data, board_done, rd_req, rd_line, rd_idx,
        input  rd_valid, rd_data, rd_oob, line_count, ready, overflow, proto_err
    );

    modport slave (
        input  wr_valid, wr_header, wr_data, board_done, rd_req, rd_line, rd_idx,
        output rd_valid, rd_data, rd_oob, line_count, ready, overflow, proto_err
    );
endinterface

// File: rtl/option_store.sv
// Option-word store: collects per-line option lists from the parser, then serves
// two-stage pipelined indexed reads to the solver once the board is complete.
module option_store #(
    parameter int unsigned MAX_LINES = 22,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned W         = 16
) (
    input logic           clk,
    input logic           rst,
    option_store_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StReady = 2'd2
    } state_e;

    state_e                       r_state;
    state_e                       w_state_next;
    logic [CW-1:0]                r_wr_ptr;
    logic [4:0]                   r_cur_line;
    logic                         r_discard;
    logic                         r_overflow;
    logic                         r_proto_err;
    logic [MAX_LINES-1:0][CW-1:0] r_line_count;
    logic [MAX_LINES-1:0][CW-1:0] r_base;
    logic [W-1:0]                 r_mem [DEPTH];

    logic [4:0] w_hdr_idx;
    logic       w_hdr;
    logic       w_opt;
    logic       w_hdr_ok;
    logic       w_hdr_bad;
    logic       w_hdr_accept;
    logic       w_new_board;
    logic       w_opt_write;
    logic       w_opt_overflow;
    logic       w_opt_proto;

    logic          w_rd_accept;
    logic          w_rd_line_ok;
    logic          w_rd_oob;
    logic [CW-1:0] w_rd_count;
    logic [CW-1:0] w_rd_base;
    logic [CW-1:0] w_rd_addr;
    logic          r_s1_valid;
    logic          r_s1_oob;
    logic [CW-1:0] r_s1_addr;
    logic          r_rd_valid;
    logic          r_rd_oob;
    logic [W-1:0]  r_rd_data;

    assign w_hdr_idx = bus.wr_data[4:0];
    assign w_hdr     = bus.wr_valid && bus.wr_header;
    assign w_opt     = bus.wr_valid && !bus.wr_header;
    assign w_hdr_ok  = w_hdr && (32'(w_hdr_idx) < MAX_LINES);
    assign w_hdr_bad = w_hdr && !w_hdr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_hdr_accept   = 1'b0;
        w_new_board    = 1'b0;
        w_opt_write    = 1'b0;
        w_opt_overflow = 1'b0;
        w_opt_proto    = 1'b0;
        case (r_state)
            StIdle: begin
                w_opt_proto = w_opt;
                if (w_hdr_ok) begin
                    w_hdr_accept = 1'b1;
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                if (w_hdr_ok) begin
                    w_hdr_accept = 1'b1;
                end else if (w_opt) begin
                    if (r_discard) begin
                        w_opt_proto = 1'b1;
                    end else if (r_wr_ptr == CW'(DEPTH)) begin
                        w_opt_overflow = 1'b1;
                    end else begin
                        w_opt_write = 1'b1;
                    end
                end
                // The coincident word above is committed on the same edge as the transition.
                if (bus.board_done) begin
                    w_state_next = StReady;
                end
            end
            StReady: begin
                if (w_hdr_ok && (w_hdr_idx == 5'd0)) begin
                    w_hdr_accept = 1'b1;
                    w_new_board  = 1'b1;
                    w_state_next = StLoad;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_cur_line   <= '0;
            r_discard    <= 1'b0;
            r_overflow   <= 1'b0;
            r_proto_err  <= 1'b0;
            r_line_count <= '0;
            r_base       <= '0;
        end else begin
            if (w_new_board) begin
                r_wr_ptr     <= '0;
                r_line_count <= '0;
                r_overflow   <= 1'b0;
                r_proto_err  <= 1'b0;
            end
            if (w_hdr_accept) begin
                r_cur_line              <= w_hdr_idx;
                r_discard               <= 1'b0;
                r_base[w_hdr_idx]       <= w_new_board ? '0 : r_wr_ptr;
                r_line_count[w_hdr_idx] <= '0;
            end
            if (w_hdr_bad) begin
                r_proto_err <= 1'b1;
                r_discard   <= 1'b1;
            end
            if (w_opt_proto) begin
                r_proto_err <= 1'b1;
            end
            if (w_opt_overflow) begin
                r_overflow <= 1'b1;
            end
            if (w_opt_write) begin
                r_wr_ptr                 <= r_wr_ptr + CW'(1);
                r_line_count[r_cur_line] <= r_line_count[r_cur_line] + CW'(1);
            end
        end
    end

    // Storage is deliberately not reset; line counts gate every read of it.
    always_ff @(posedge clk) begin
        if (w_opt_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    always_comb begin
        w_rd_accept  = bus.rd_req && (r_state == StReady);
        w_rd_line_ok = 32'(bus.rd_line) < MAX_LINES;
        w_rd_count   = '0;
        w_rd_base    = '0;
        if (w_rd_line_ok) begin
            w_rd_count = r_line_count[bus.rd_line];
            w_rd_base  = r_base[bus.rd_line];
        end
        w_rd_addr = w_rd_base + {1'b0, bus.rd_idx};
        w_rd_oob  = !w_rd_line_ok || ({1'b0, bus.rd_idx} >= w_rd_count) || w_rd_addr[AW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_oob   <= 1'b0;
            r_s1_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_accept;
            r_s1_oob   <= w_rd_oob;
            r_s1_addr  <= w_rd_addr;
            r_rd_valid <= r_s1_valid;
            r_rd_oob   <= r_s1_valid && r_s1_oob;
            r_rd_data  <= (r_s1_valid && !r_s1_oob) ? r_mem[r_s1_addr[AW-1:0]] : '0;
        end
    end

    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_oob     = r_rd_oob;
    assign bus.rd_data    = r_rd_data;
    assign bus.line_count = r_line_count;
    assign bus.ready      = (r_state == StReady);
    assign bus.overflow   = r_overflow;
    assign bus.proto_err  = r_proto_err;
endmodule

// File: tb/tb_option_store.sv
// Randomised scoreboard bench: a full-size store and a 4-word store share one stimulus
// stream and are checked against a per-line list model of the board.
module tb_option_store;
    localparam int MAXL = 22;
    localparam int MIDLE = 0;
    localparam int MLOAD = 1;
    localparam int MREADY = 2;

    typedef struct {
        int cyc;
        bit oob;
        int data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_header;
    logic [15:0] wr_data;
    logic        board_done;
    logic        rd_req;
    logic [4:0]  rd_line;
    logic [9:0]  rd_idx;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    exp_t        sb[2][$];
    int          m_state[2];
    int          m_cur[2];
    bit          m_disc[2];
    int          m_total[2];
    bit          m_ovf[2];
    bit          m_perr[2];
    int          m_cnt[2][MAXL];
    logic [15:0] m_words[2][MAXL][1024];

    logic        rdv[2];
    logic        rdo[2];
    logic [15:0] rdd[2];
    logic        rdy[2];
    logic        ovf[2];
    logic        perr[2];
    int          lc[2][MAXL];

    option_store_if #(.MAX_LINES(MAXL), .DEPTH(1024), .W(16)) bus0 ();
    option_store_if #(.MAX_LINES(MAXL), .DEPTH(4), .W(16)) bus1 ();

    option_store #(.MAX_LINES(MAXL), .DEPTH(1024), .W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    option_store #(.MAX_LINES(MAXL), .DEPTH(4), .W(16)) u_small (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    assign bus0.wr_valid = wr_valid;
    assign bus0.wr_header = wr_header;
    assign bus0.wr_data = wr_data;
    assign bus0.board_done = board_done;
    assign bus0.rd_req = rd_req;
    assign bus0.rd_line = rd_line;
    assign bus0.rd_idx = rd_idx;
    assign bus1.wr_valid = wr_valid;
    assign bus1.wr_header = wr_header;
    assign bus1.wr_data = wr_data;
    assign bus1.board_done = board_done;
    assign bus1.rd_req = rd_req;
    assign bus1.rd_line = rd_line;
    assign bus1.rd_idx = rd_idx[1:0];

    assign rdv[0] = bus0.rd_valid;
    assign rdv[1] = bus1.rd_valid;
    assign rdo[0] = bus0.rd_oob;
    assign rdo[1] = bus1.rd_oob;
    assign rdd[0] = bus0.rd_data;
    assign rdd[1] = bus1.rd_data;
    assign rdy[0] = bus0.ready;
    assign rdy[1] = bus1.ready;
    assign ovf[0] = bus0.overflow;
    assign ovf[1] = bus1.overflow;
    assign perr[0] = bus0.proto_err;
    assign perr[1] = bus1.proto_err;

    always_comb begin
        for (int l = 0; l < MAXL; l++) begin
            lc[0][l] = int'(bus0.line_count[l]);
            lc[1][l] = int'(bus1.line_count[l]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int dep(input int d);
        return (d == 0) ? 1024 : 4;
    endfunction

    function automatic void open_line(input int d, input int idx);
        m_cur[d] = idx;
        m_cnt[d][idx] = 0;
        m_disc[d] = 1'b0;
    endfunction

    function automatic void clear_board(input int d);
        m_total[d] = 0;
        m_ovf[d] = 1'b0;
        m_perr[d] = 1'b0;
        for (int l = 0; l < MAXL; l++) m_cnt[d][l] = 0;
    endfunction

    // Reference: each line is a list of words; a new header for a line restarts its list.
    function automatic void model_step(input int d);
        int idx;
        bit hdr_ok;
        bit opt;
        idx = int'(wr_data[4:0]);
        hdr_ok = wr_valid && wr_header && (idx < MAXL);
        opt = wr_valid && !wr_header;
        if (rst) begin
            clear_board(d);
            m_state[d] = MIDLE;
            m_disc[d] = 1'b0;
            m_cur[d] = 0;
            return;
        end
        if (wr_valid && wr_header && !hdr_ok) begin
            m_perr[d] = 1'b1;
            m_disc[d] = 1'b1;
        end
        if (m_state[d] == MIDLE) begin
            if (opt) m_perr[d] = 1'b1;
            if (hdr_ok) begin
                open_line(d, idx);
                m_state[d] = MLOAD;
            end
        end else if (m_state[d] == MLOAD) begin
            if (hdr_ok) begin
                open_line(d, idx);
            end else if (opt) begin
                if (m_disc[d]) m_perr[d] = 1'b1;
                else if (m_total[d] >= dep(d)) m_ovf[d] = 1'b1;
                else begin
                    m_words[d][m_cur[d]][m_cnt[d][m_cur[d]]] = wr_data;
                    m_cnt[d][m_cur[d]]++;
                    m_total[d]++;
                end
            end
            if (board_done) m_state[d] = MREADY;
        end else if (hdr_ok && idx == 0) begin
            clear_board(d);
            open_line(d, 0);
            m_state[d] = MLOAD;
        end
    endfunction

    task automatic tick();
        exp_t e;
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                sb[d].delete();
            end else if (rd_req && m_state[d] == MREADY) begin
                idx = (d == 0) ? int'(rd_idx) : int'(rd_idx[1:0]);
                e.cyc = cyc_n + 2;
                e.oob = (int'(rd_line) >= MAXL) || (idx >= m_cnt[d][int'(rd_line) % MAXL]);
                e.data = e.oob ? 0 : int'(m_words[d][rd_line][idx]);
                sb[d].push_back(e);
            end
            model_step(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst = 1'b0;
        wr_valid = 1'b0;
        wr_header = 1'b0;
        wr_data = '0;
        board_done = 1'b0;
        rd_req = 1'b0;
        rd_line = '0;
        rd_idx = '0;
    endtask

    task automatic do_rst();
        clr(); rst = 1'b1; tick(); clr();
    endtask

    task automatic hdr(input int idx);
        clr(); wr_valid = 1'b1; wr_header = 1'b1;
        wr_data = {11'($urandom), 5'(idx)};
        tick(); clr();
    endtask

    task automatic opt(input logic [15:0] v, input bit done);
        clr(); wr_valid = 1'b1; wr_data = v; board_done = done; tick(); clr();
    endtask

    task automatic finish_board();
        clr(); board_done = 1'b1; tick(); clr();
    endtask

    task automatic rd(input int line, input int idx);
        clr(); rd_req = 1'b1; rd_line = 5'(line); rd_idx = 10'(idx); tick(); clr();
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_status(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d ready", tag, d), int'(rdy[d]), int'(m_state[d] == MREADY));
            chk($sformatf("%s dut%0d overflow", tag, d), int'(ovf[d]), int'(m_ovf[d]));
            chk($sformatf("%s dut%0d proto_err", tag, d), int'(perr[d]), int'(m_perr[d]));
            for (int l = 0; l < MAXL; l++)
                chk($sformatf("%s dut%0d line_count[%0d]", tag, d, l), lc[d][l], m_cnt[d][l]);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rdv[d] === 1'b1) begin
                if (sb[d].size() == 0) begin
                    chk($sformatf("dut%0d unexpected rd_valid", d), 1, 0);
                end else begin
                    e = sb[d].pop_front();
                    chk($sformatf("dut%0d rd latency cycle", d), cyc_n, e.cyc);
                    chk($sformatf("dut%0d rd_oob", d), int'(rdo[d]), int'(e.oob));
                    chk($sformatf("dut%0d rd_data", d), int'(rdd[d]), e.data);
                end
            end else if (sb[d].size() != 0 && sb[d][0].cyc <= cyc_n) begin
                chk($sformatf("dut%0d missing rd_valid", d), 0, 1);
                void'(sb[d].pop_front());
            end
        end
    end

    task automatic rand_board();
        int n;
        int r;
        int line;
        if (m_state[0] == MREADY && $urandom_range(0, 2) != 0) hdr(0);
        else begin
            do_rst();
            hdr($urandom_range(0, MAXL - 1));
        end
        n = $urandom_range(4, 40);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) hdr(($urandom_range(0, 9) == 0) ? $urandom_range(MAXL, 31)
                                                      : $urandom_range(0, MAXL - 1));
            else if (r < 93) opt(16'($urandom), (i == n - 1) && r[0]);
            else if (r < 98) rd($urandom_range(0, 23), $urandom_range(0, 3));
            else do_rst();
        end
        if (m_state[0] != MREADY) finish_board();
        idle(1);
        check_status("board");
        n = $urandom_range(8, 24);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            else begin
                line = $urandom_range(0, 23);
                rd(line, $urandom_range(0, (line < MAXL ? m_cnt[0][line] : 0) + 1));
            end
        end
        idle(3);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        clr();
        check_status("reset");
        chk("reset rd_valid", int'(rdv[0]), 0);

        // Protocol errors: option before header, bad header in IDLE and in LOAD.
        opt(16'h00aa, 1'b0);
        check_status("opt before hdr");
        hdr(30);
        opt(16'h00bb, 1'b0);
        hdr(0);
        opt(16'h0101, 1'b0);
        hdr(30);
        opt(16'h0202, 1'b0);
        hdr(1);
        opt(16'h0303, 1'b1);
        idle(1);
        check_status("discard");
        rd(0, 0); rd(0, 1); rd(1, 0);
        idle(3);

        // New board from READY, then overflow on the small store.
        hdr(0);
        check_status("new board");
        for (int i = 0; i < 6; i++) opt(16'(16'h0011 + i), 1'b0);
        finish_board();
        idle(1);
        check_status("overflow");
        rd(0, 3); rd(0, 5);
        idle(3);

        // Reference load, out-of-range and back-to-back reads.
        do_rst();
        hdr(0); opt(16'h0003, 1'b0); opt(16'h0006, 1'b0);
        hdr(1); opt(16'h0005, 1'b0);
        finish_board();
        idle(1);
        check_status("basic load");
        rd(0, 1); rd(1, 1); rd(25, 0);
        idle(2);
        rd(0, 0); rd(0, 1); rd(1, 0); rd(0, 0);
        idle(3);

        // Reset in the middle of a load.
        do_rst();
        hdr(3); opt(16'h1234, 1'b0); opt(16'h5678, 1'b0);
        do_rst();
        check_status("rst mid-load");

        for (int b = 0; b < 60; b++) rand_board();

        idle(4);
        chk("scoreboard drained dut0", sb[0].size(), 0);
        chk("scoreboard drained dut1", sb[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
